// File: rtl/head_assembler.sv
// head_assembler
// ----------------------------------------------------------------------------
// Ingress stage in front of the per-layer parser pipeline. Each input beat is
// forwarded unchanged to the packet buffer. The first HEAD_WIDTH bits of each
// packet are also collected into a header vector, with the first beat in the
// MSBs. The header and a zero metadata vector are launched together as a
// one-cycle pulse. Each carries a tag: a valid flag plus a packet sequence
// number.
//
// Ports
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_data_valid/i_data/i_data_last  ingress beat stream
//   o_data_ready          ingress ready (mirrors i_pay_ready)
//   o_pay_valid/o_pay_data/o_pay_last  beat stream to packet buffer
//   i_pay_ready           packet buffer ready
//   o_head                {tag, header}  one-cycle pulse, zero otherwise
//   o_meta                {tag, zeros}   pulses together with o_head
//   o_pkt_cnt             packets headed            (HEAD_ASM_STATS_EN)
//   o_short_cnt           packets shorter than head (HEAD_ASM_STATS_EN)
//   o_dbg_state           current FSM state (0 = COLLECT, 1 = DRAIN)
//
// Handshake: a beat transfers on a cycle where valid and ready are both high.
// Valid never depends on ready. The ingress side is transparent to the
// packet-buffer side, so both ends see the same transfer.
//
// Optional feature macro: HEAD_ASM_STATS_EN enables the two statistics
// counters. When it is undefined, both counter outputs are tied to zero.
// ----------------------------------------------------------------------------
module head_assembler #(
  parameter int DATA_WIDTH    = 256,
  parameter int HEAD_WIDTH    = 1024,
  parameter int META_WIDTH    = 1024,
  parameter int TAG_WIDTH     = 8,
  parameter int TAG_VALID_BIT = 0
) (
  input  logic                             i_clk,
  input  logic                             i_rst,
  input  logic                             i_data_valid,
  input  logic [DATA_WIDTH-1:0]            i_data,
  input  logic                             i_data_last,
  output logic                             o_data_ready,
  output logic                             o_pay_valid,
  output logic [DATA_WIDTH-1:0]            o_pay_data,
  output logic                             o_pay_last,
  input  logic                             i_pay_ready,
  output logic [HEAD_WIDTH+TAG_WIDTH-1:0]  o_head,
  output logic [META_WIDTH+TAG_WIDTH-1:0]  o_meta,
  output logic [31:0]                      o_pkt_cnt,
  output logic [31:0]                      o_short_cnt,
  output logic                             o_dbg_state
);

  localparam int N     = HEAD_WIDTH / DATA_WIDTH;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam int SEQ_W = TAG_WIDTH - 1;

  typedef enum logic {COLLECT = 1'b0, DRAIN = 1'b1} state_e;

  state_e                           state_q, state_d;
  logic [CNT_W-1:0]                 cnt_q, cnt_d;
  logic [HEAD_WIDTH-1:0]            acc_q, acc_d;
  logic [SEQ_W-1:0]                 seq_q, seq_d;
  logic [HEAD_WIDTH+TAG_WIDTH-1:0]  head_q, head_d;
  logic [META_WIDTH+TAG_WIDTH-1:0]  meta_q, meta_d;

  logic                  accept;
  logic                  last_slot;
  logic                  emit;
  logic                  short_emit;
  logic [HEAD_WIDTH-1:0] merged;
  logic [TAG_WIDTH-1:0]  tag;

  // Put the valid flag at TAG_VALID_BIT. The sequence bits fill the
  // remaining positions in order, so {seq, 1'b1} is the result when
  // TAG_VALID_BIT is 0.
  function automatic logic [TAG_WIDTH-1:0] make_tag(input logic [SEQ_W-1:0] seq);
    logic [TAG_WIDTH-1:0] s;
    logic [TAG_WIDTH-1:0] low_mask;
    logic [TAG_WIDTH-1:0] flag;
    s        = {1'b0, seq};
    flag     = TAG_WIDTH'(1) << TAG_VALID_BIT;
    low_mask = flag - TAG_WIDTH'(1);
    return ((s & ~low_mask) << 1) | (s & low_mask) | flag;
  endfunction

  // Payload path: pure pass-through, no buffering.
  assign o_data_ready = i_pay_ready;
  assign o_pay_valid  = i_data_valid;
  assign o_pay_data   = i_data;
  assign o_pay_last   = i_data_last;

  assign accept     = i_data_valid && i_pay_ready;
  assign last_slot  = (cnt_q == CNT_W'(N - 1));
  assign emit       = accept && (state_q == COLLECT) && (last_slot || i_data_last);
  assign short_emit = emit && i_data_last && !last_slot;
  assign tag        = make_tag(seq_q);

  // The current beat goes into slice cnt_q, counted down from the MSBs.
  // Slices that have not been written yet are still zero, so OR-ing the
  // shifted beat in writes the slice.
  assign merged = acc_q | ((HEAD_WIDTH'(i_data) << (HEAD_WIDTH - DATA_WIDTH))
                           >> (cnt_q * DATA_WIDTH));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    seq_d   = seq_q;
    head_d  = '0;
    meta_d  = '0;
    unique case (state_q)
      COLLECT: begin
        if (accept) begin
          if (emit) begin
            head_d  = {tag, merged};
            meta_d  = {tag, {META_WIDTH{1'b0}}};
            seq_d   = seq_q + 1'b1;
            // Clear here so the next packet can start on the next cycle.
            cnt_d   = '0;
            acc_d   = '0;
            state_d = i_data_last ? COLLECT : DRAIN;
          end else begin
            acc_d = merged;
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      DRAIN: begin
        if (accept && i_data_last) begin
          state_d = COLLECT;
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= COLLECT;
      cnt_q   <= '0;
      acc_q   <= '0;
      seq_q   <= '0;
      head_q  <= '0;
      meta_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      seq_q   <= seq_d;
      head_q  <= head_d;
      meta_q  <= meta_d;
    end
  end

  assign o_head      = head_q;
  assign o_meta      = meta_q;
  assign o_dbg_state = state_q;

`ifdef HEAD_ASM_STATS_EN
  logic [31:0] pkt_cnt_q, pkt_cnt_d;
  logic [31:0] short_cnt_q, short_cnt_d;

  always_comb begin
    pkt_cnt_d   = pkt_cnt_q;
    short_cnt_d = short_cnt_q;
    if (emit) begin
      pkt_cnt_d = pkt_cnt_q + 32'd1;
    end
    if (short_emit) begin
      short_cnt_d = short_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pkt_cnt_q   <= '0;
      short_cnt_q <= '0;
    end else begin
      pkt_cnt_q   <= pkt_cnt_d;
      short_cnt_q <= short_cnt_d;
    end
  end

  assign o_pkt_cnt   = pkt_cnt_q;
  assign o_short_cnt = short_cnt_q;
`else
  assign o_pkt_cnt   = 32'd0;
  assign o_short_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_head_assembler.sv
// tb_head_assembler
// ----------------------------------------------------------------------------
// Directed and random stimulus for head_assembler at its default parameters.
// The reference model works at packet level. It tracks the position of each
// beat inside its packet and builds the expected header from the first
// HEAD_WIDTH/DATA_WIDTH beats. It also keeps a running sequence number and
// packet/short-packet totals. Every cycle it compares the pass-through
// stream, o_head, o_meta and the counters.
// ----------------------------------------------------------------------------
module tb_head_assembler;

  localparam int DW   = 256;
  localparam int HW   = 1024;
  localparam int MW   = 1024;
  localparam int TW   = 8;
  localparam int N    = HW / DW;

  logic                i_clk = 1'b0;
  logic                i_rst;
  logic                i_data_valid;
  logic [DW-1:0]       i_data;
  logic                i_data_last;
  logic                o_data_ready;
  logic                o_pay_valid;
  logic [DW-1:0]       o_pay_data;
  logic                o_pay_last;
  logic                i_pay_ready;
  logic [HW+TW-1:0]    o_head;
  logic [MW+TW-1:0]    o_meta;
  logic [31:0]         o_pkt_cnt;
  logic [31:0]         o_short_cnt;
  logic                o_dbg_state;

  head_assembler dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_data_valid (i_data_valid),
    .i_data       (i_data),
    .i_data_last  (i_data_last),
    .o_data_ready (o_data_ready),
    .o_pay_valid  (o_pay_valid),
    .o_pay_data   (o_pay_data),
    .o_pay_last   (o_pay_last),
    .i_pay_ready  (i_pay_ready),
    .o_head       (o_head),
    .o_meta       (o_meta),
    .o_pkt_cnt    (o_pkt_cnt),
    .o_short_cnt  (o_short_cnt),
    .o_dbg_state  (o_dbg_state)
  );

  // Clock
  always #5 i_clk = ~i_clk;

  // Scoreboard state
  int checks   = 0;
  int failures = 0;

  int               pos;          // beat index within the current packet
  logic [HW-1:0]    m_hdr;
  logic [TW-2:0]    m_seq;
  logic [HW+TW-1:0] exp_head_now, exp_head_next;
  logic [MW+TW-1:0] exp_meta_now, exp_meta_next;
  logic [31:0]      exp_pkt_now, exp_pkt_next;
  logic [31:0]      exp_short_now, exp_short_next;

  task automatic chk(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic check_outputs(input logic v, input logic [DW-1:0] d, input logic l, input logic r);
    chk("data_ready", DW'(o_data_ready), DW'(r));
    chk("pay_valid",  DW'(o_pay_valid),  DW'(v));
    chk("pay_data",   o_pay_data,        d);
    chk("pay_last",   DW'(o_pay_last),   DW'(l));
    chk("head_tag",   DW'(o_head[HW+TW-1:HW]), DW'(exp_head_now[HW+TW-1:HW]));
    for (int s = 0; s < N; s++) begin
      chk($sformatf("head_slice%0d", s), o_head[HW-1-s*DW -: DW], exp_head_now[HW-1-s*DW -: DW]);
    end
    chk("meta_tag",   DW'(o_meta[MW+TW-1:MW]), DW'(exp_meta_now[MW+TW-1:MW]));
    for (int s = 0; s < MW/DW; s++) begin
      chk($sformatf("meta_slice%0d", s), o_meta[MW-1-s*DW -: DW], exp_meta_now[MW-1-s*DW -: DW]);
    end
`ifdef HEAD_ASM_STATS_EN
    chk("pkt_cnt",   DW'(o_pkt_cnt),   DW'(exp_pkt_now));
    chk("short_cnt", DW'(o_short_cnt), DW'(exp_short_now));
`else
    chk("pkt_cnt",   DW'(o_pkt_cnt),   '0);
    chk("short_cnt", DW'(o_short_cnt), '0);
`endif
  endtask

  // Driver for one clock cycle. The inputs are applied just after the active
  // edge. The outputs are checked mid-cycle, and then the model advances.
  task automatic step(input logic v, input logic [DW-1:0] d, input logic l, input logic r);
    logic [TW-1:0] tag;
    i_data_valid = v;
    i_data       = d;
    i_data_last  = l;
    i_pay_ready  = r;
    exp_head_next  = '0;
    exp_meta_next  = '0;
    exp_pkt_next   = exp_pkt_now;
    exp_short_next = exp_short_now;
    #3;
    check_outputs(v, d, l, r);
    if (v && r) begin
      if (pos < N) begin
        if (pos == 0) m_hdr = '0;
        m_hdr = m_hdr | (HW'(d) << (HW - (pos + 1) * DW));
        if (pos == N - 1 || l) begin
          tag            = {m_seq, 1'b1};
          exp_head_next  = {tag, m_hdr};
          exp_meta_next  = {tag, {MW{1'b0}}};
          m_seq          = m_seq + 1'b1;
          exp_pkt_next   = exp_pkt_now + 32'd1;
          if (pos < N - 1) exp_short_next = exp_short_now + 32'd1;
        end
      end
      pos = l ? 0 : pos + 1;
    end
    @(posedge i_clk);
    #1;
    exp_head_now  = exp_head_next;
    exp_meta_now  = exp_meta_next;
    exp_pkt_now   = exp_pkt_next;
    exp_short_now = exp_short_next;
  endtask

  task automatic model_reset();
    pos           = 0;
    m_hdr         = '0;
    m_seq         = '0;
    exp_head_now  = '0;
    exp_meta_now  = '0;
    exp_pkt_now   = '0;
    exp_short_now = '0;
  endtask

  task automatic do_reset();
    i_rst        = 1'b1;
    i_data_valid = 1'b0;
    i_data_last  = 1'b0;
    @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    model_reset();
  endtask

  function automatic logic [DW-1:0] rep(input logic [7:0] b);
    return {(DW/8){b}};
  endfunction

  function automatic logic [DW-1:0] rnd_beat();
    return {$urandom(), $urandom(), $urandom(), $urandom(),
            $urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Sends a packet back to back at full rate with ready held high.
  task automatic send_pkt(input logic [DW-1:0] beats[$]);
    for (int i = 0; i < beats.size(); i++) begin
      step(1'b1, beats[i], i == beats.size() - 1, 1'b1);
    end
  endtask

  initial begin
    logic [DW-1:0] q[$];
    logic [DW-1:0] b;
    int len;

    i_rst        = 1'b1;
    i_data_valid = 1'b0;
    i_data       = '0;
    i_data_last  = 1'b0;
    i_pay_ready  = 1'b1;
    @(posedge i_clk);
    @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    model_reset();

    // Reset state
    step(1'b0, '0, 1'b0, 1'b1);

    // 6-beat packet: header from beats 0..3, beats 4..5 only on payload
    q = {};
    for (int i = 0; i < 6; i++) q.push_back(rep(8'hA0 + 8'(i)));
    send_pkt(q);
    step(1'b0, '0, 1'b0, 1'b1);

    // One-beat packet followed immediately by a 4-beat packet
    q = {};
    q.push_back(rep(8'hFF));
    send_pkt(q);
    q = {};
    for (int i = 0; i < 4; i++) q.push_back(rep(8'hB0 + 8'(i)));
    send_pkt(q);
    step(1'b0, '0, 1'b0, 1'b1);

    // Ready low for 3 cycles mid-header
    step(1'b1, rep(8'hC0), 1'b0, 1'b1);
    step(1'b1, rep(8'hC1), 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b1, rep(8'hC2), 1'b0, 1'b0);
    step(1'b1, rep(8'hC2), 1'b0, 1'b1);
    step(1'b1, rep(8'hC3), 1'b1, 1'b1);
    step(1'b0, '0, 1'b0, 1'b1);

    // Idle for 20 cycles
    for (int i = 0; i < 20; i++) step(1'b0, rnd_beat(), 1'b0, 1'(($urandom() & 1)));

    // Sequence-number wrap: 130 one-beat packets from a fresh reset
    do_reset();
    for (int i = 0; i < 130; i++) step(1'b1, rnd_beat(), 1'b1, 1'b1);
    step(1'b0, '0, 1'b0, 1'b1);

    // Abort a packet with reset after beat 1, then send a fresh packet
    step(1'b1, rep(8'hD0), 1'b0, 1'b1);
    step(1'b1, rep(8'hD1), 1'b0, 1'b1);
    do_reset();
    q = {};
    for (int i = 0; i < 4; i++) q.push_back(rep(8'hE0 + 8'(i)));
    send_pkt(q);
    step(1'b0, '0, 1'b0, 1'b1);

    // Random packets with idle and stall cycles
    for (int p = 0; p < 40; p++) begin
      len = $urandom_range(1, 7);
      for (int i = 0; i < len; i++) begin
        b = rnd_beat();
        while ($urandom_range(0, 3) == 0) begin
          if ($urandom_range(0, 1) == 0) step(1'b0, rnd_beat(), 1'b0, 1'b1);
          else                           step(1'b1, b, i == len - 1, 1'b0);
        end
        step(1'b1, b, i == len - 1, 1'b1);
      end
    end
    step(1'b0, '0, 1'b0, 1'b1);
    step(1'b0, '0, 1'b0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
